// File: rtl/rnn_dense_argmax.sv
// rtl/rnn_dense_argmax.sv - dense projection with serial MAC and arg-max output stage
module rnn_dense_argmax #(
    parameter int HIDDEN  = 4,
    parameter int CLASSES = 8,
    parameter int W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [7:0]            w_row,
    input  logic [7:0]            w_col,
    input  logic [W-1:0]          w_data,
    input  logic                  h_valid,
    output logic                  h_ready,
    input  logic [HIDDEN*W-1:0]   h_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_class,
    output logic [W-1:0]          out_score
);

    // Accumulator is wide enough that HIDDEN full-scale products plus a bias never wrap.
    localparam int AW = 2*W + $clog2(HIDDEN+1);
    localparam int CW = $clog2(CLASSES);
    localparam int KW = $clog2(HIDDEN+1);

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_CMP, S_DONE} state_t;

    state_t                state;
    logic signed [W-1:0]   wmem [CLASSES][HIDDEN+1];
    logic [HIDDEN*W-1:0]   h_snap;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  best_acc;
    logic [CW-1:0]         best_idx;
    logic [CW-1:0]         c;
    logic [KW-1:0]         k;

    logic signed [W-1:0]   w_cur;
    logic signed [W-1:0]   h_cur;
    logic signed [2*W-1:0] prod;
    logic [CW-1:0]         c_next;
    logic signed [W-1:0]   bias_first;
    logic signed [W-1:0]   bias_next;
    logic                  take;
    logic signed [AW-1:0]  nb_acc;
    logic [CW-1:0]         nb_idx;
    logic [W-1:0]          sat_score;
    logic                  w_hit;

    // Operand selection, product, running best and output clamp.
    always_comb begin
        w_cur = wmem[c][k];
        h_cur = '0;
        for (int i = 0; i < HIDDEN; i++) begin
            if (k == KW'(i)) h_cur = h_snap[i*W +: W];
        end
        prod       = w_cur * h_cur;
        c_next     = c + CW'(1);
        bias_first = wmem[0][KW'(HIDDEN)];
        bias_next  = wmem[c_next][KW'(HIDDEN)];
        // Strict greater-than keeps the lowest index on ties.
        take       = (c == '0) || (acc > best_acc);
        nb_acc     = take ? acc : best_acc;
        nb_idx     = take ? c : best_idx;
        if (nb_acc > SAT_MAX)      sat_score = SAT_MAX[W-1:0];
        else if (nb_acc < SAT_MIN) sat_score = SAT_MIN[W-1:0];
        else                       sat_score = nb_acc[W-1:0];
        w_hit = w_en && (w_row < 8'(CLASSES)) && (w_col <= 8'(HIDDEN));
    end

    // Control FSM, parameter storage and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            h_ready   <= 1'b1;
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            h_snap    <= '0;
            acc       <= '0;
            best_acc  <= '0;
            best_idx  <= '0;
            c         <= '0;
            k         <= '0;
            for (int r = 0; r < CLASSES; r++) begin
                for (int q = 0; q <= HIDDEN; q++) begin
                    wmem[r][q] <= '0;
                end
            end
        end else begin
            // Parameters may only change while no projection is in flight.
            if (w_hit && (state == S_IDLE || state == S_DONE)) begin
                wmem[w_row[CW-1:0]][w_col[KW-1:0]] <= w_data;
            end
            case (state)
                S_IDLE: begin
                    if (h_valid) begin
                        h_snap  <= h_vec;
                        acc     <= {{(AW-W){bias_first[W-1]}}, bias_first};
                        c       <= '0;
                        k       <= '0;
                        h_ready <= 1'b0;
                        state   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + {{(AW-2*W){prod[2*W-1]}}, prod};
                    if (k == KW'(HIDDEN-1)) state <= S_CMP;
                    else                    k     <= k + KW'(1);
                end
                S_CMP: begin
                    best_acc <= nb_acc;
                    best_idx <= nb_idx;
                    if (c == CW'(CLASSES-1)) begin
                        out_valid <= 1'b1;
                        out_class <= {{(8-CW){1'b0}}, nb_idx};
                        out_score <= sat_score;
                        state     <= S_DONE;
                    end else begin
                        c     <= c_next;
                        k     <= '0;
                        acc   <= {{(AW-W){bias_next[W-1]}}, bias_next};
                        state <= S_MAC;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        h_ready   <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_dense_argmax.sv
// tb/tb_rnn_dense_argmax.sv - directed self-checking bench for rnn_dense_argmax
module tb_rnn_dense_argmax;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic [7:0]  w_row;
    logic [7:0]  w_col;
    logic [15:0] w_data;
    logic        h_valid;
    logic        h_ready;
    logic [63:0] h_vec;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_class;
    logic [15:0] out_score;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    rnn_dense_argmax #(.HIDDEN(4), .CLASSES(8), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .w_row     (w_row),
        .w_col     (w_col),
        .w_data    (w_data),
        .h_valid   (h_valid),
        .h_ready   (h_ready),
        .h_vec     (h_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic write_w(input int r, input int col, input int d);
        w_en = 1'b1; w_row = 8'(r); w_col = 8'(col); w_data = 16'(d);
        @(posedge clk); #1;
        w_en = 1'b0;
    endtask

    task automatic clear_all();
        for (int r = 0; r < 8; r++)
            for (int q = 0; q <= 4; q++)
                write_w(r, q, 0);
    endtask

    task automatic load_identity();
        clear_all();
        for (int r = 0; r < 4; r++) write_w(r, r, 1);
    endtask

    task automatic run_vec(input string tag, input logic [63:0] hv, input int ec, input int es,
                           input int hold, input bit mac_wr);
        int n;
        chk({tag, "_idle_ready"}, $signed({1'b0, h_ready}), 1);
        h_vec = hv; h_valid = 1'b1;
        @(posedge clk); #1;
        h_valid = 1'b0;
        h_vec = ~hv;
        if (mac_wr) begin
            w_en = 1'b1; w_row = 8'd3; w_col = 8'd4; w_data = 16'd100;
        end
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            w_en = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, n, 40);
        chk({tag, "_class"}, $signed({1'b0, out_class}), ec);
        chk({tag, "_score"}, $signed(out_score), es);
        chk({tag, "_busy_ready"}, $signed({1'b0, h_ready}), 0);
        for (int i = 0; i < hold; i++) begin
            h_valid = (i % 2 == 0);
            h_vec = pack4(i, i, i, i);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, $signed({1'b0, out_valid}), 1);
            chk({tag, "_hold_ready"}, $signed({1'b0, h_ready}), 0);
            chk({tag, "_hold_class"}, $signed({1'b0, out_class}), ec);
            chk({tag, "_hold_score"}, $signed(out_score), es);
        end
        h_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_consumed_valid"}, $signed({1'b0, out_valid}), 0);
        chk({tag, "_consumed_ready"}, $signed({1'b0, h_ready}), 1);
        @(posedge clk); #1;
        chk({tag, "_stay_idle"}, $signed({1'b0, out_valid}), 0);
    endtask

    initial begin
        int n;
        int acc_cyc;
        int prev_cyc;
        logic [63:0] va;
        logic [63:0] vb;

        rst = 1'b1; w_en = 1'b0; w_row = '0; w_col = '0; w_data = '0;
        h_valid = 1'b0; h_vec = '0; out_ready = 1'b0;
        prev_cyc = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_h_ready", $signed({1'b0, h_ready}), 1);
        chk("rst_out_valid", $signed({1'b0, out_valid}), 0);
        chk("rst_out_class", $signed({1'b0, out_class}), 0);
        chk("rst_out_score", $signed(out_score), 0);

        // Abort mid-MAC; the loaded weight must be lost.
        write_w(0, 0, 5);
        h_vec = pack4(1, 1, 1, 1); h_valid = 1'b1;
        @(posedge clk); #1;
        h_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mac_ready_low", $signed({1'b0, h_ready}), 0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_ready", $signed({1'b0, h_ready}), 1);
        chk("async_rst_valid", $signed({1'b0, out_valid}), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_vec("post_rst", pack4(1, 1, 1, 1), 0, 0, 0, 1'b0);

        // Identity projection.
        load_identity();
        run_vec("ident", pack4(-16, -49, -57, 2), 3, 2, 0, 1'b0);

        // Bias-only with a tie between classes 2 and 6.
        clear_all();
        for (int r = 0; r < 8; r++) write_w(r, 4, 5);
        write_w(2, 4, 9);
        write_w(6, 4, 9);
        run_vec("tie", pack4(7, 8, 9, 10), 2, 9, 0, 1'b0);

        // Out-of-range writes are dropped.
        write_w(8, 0, 1000);
        write_w(0, 5, 1000);
        run_vec("oob_write", pack4(7, 8, 9, 10), 2, 9, 0, 1'b0);

        // Positive saturation without accumulator wrap.
        clear_all();
        for (int q = 0; q < 4; q++) write_w(0, q, 32767);
        write_w(1, 4, -3);
        run_vec("sat_pos", pack4(32767, 32767, 32767, 32767), 0, 32767, 0, 1'b0);

        // Negative saturation, all classes tied, with back-pressure and ignored h_valid.
        clear_all();
        for (int r = 0; r < 8; r++)
            for (int q = 0; q < 4; q++)
                write_w(r, q, -32768);
        run_vec("sat_neg_hold", pack4(32767, 32767, 32767, 32767), 0, -32768, 20, 1'b0);

        // A write during MAC is dropped for this run and the next.
        load_identity();
        run_vec("mac_write", pack4(-16, -49, -57, 2), 3, 2, 0, 1'b1);
        run_vec("after_mac_write", pack4(-16, -49, -57, 2), 3, 2, 0, 1'b0);

        // Back-to-back with alternating vectors.
        va = pack4(-16, -49, -57, 2);
        vb = pack4(10, -1, 3, -5);
        out_ready = 1'b1; h_valid = 1'b1; h_vec = va;
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (!h_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b2b_ready", $signed({1'b0, h_ready}), 1);
            @(posedge clk); #1;
            acc_cyc = cyc;
            if (r > 0) chk("b2b_period", acc_cyc - prev_cyc, 42);
            prev_cyc = acc_cyc;
            h_vec = (r % 2 == 0) ? vb : va;
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b2b_latency", n, 40);
            chk("b2b_class", $signed({1'b0, out_class}), (r % 2 == 0) ? 3 : 0);
            chk("b2b_score", $signed(out_score), (r % 2 == 0) ? 2 : 10);
            chk("b2b_exclusive", $signed({1'b0, h_ready}), 0);
            if (r == 3) h_valid = 1'b0;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_end_valid", $signed({1'b0, out_valid}), 0);
        chk("b2b_end_ready", $signed({1'b0, h_ready}), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
